// File: rtl/pip_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pip_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    // EX operand source selects
    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pip_state_e;

    // Forwarding select for one EX source operand; MEM beats WB, x0 never forwarded
    function automatic logic [FWD_W-1:0] fwd_select(
        input logic              rs_read,
        input logic [REG_AW-1:0] rs_ad,
        input logic              mem_rd_en,
        input logic [REG_AW-1:0] mem_rd_ad,
        input logic              wb_rd_en,
        input logic [REG_AW-1:0] wb_rd_ad
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_REG;
        if (rs_read && mem_rd_en && (mem_rd_ad != '0) && (mem_rd_ad == rs_ad)) begin
            sel = FWD_MEM;
        end else if (rs_read && wb_rd_en && (wb_rd_ad != '0) && (wb_rd_ad == rs_ad)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pip_fwd_unit.sv
// EX-stage operand forwarding compare for both source operands (pure combinational).
module pip_fwd_unit
    import pip_pkg::*;
(
    input  logic              ex_rs1_read,
    input  logic [REG_AW-1:0] ex_rs1_ad,
    input  logic              ex_rs2_read,
    input  logic [REG_AW-1:0] ex_rs2_ad,
    input  logic              mem_rd_en,
    input  logic [REG_AW-1:0] mem_rd_ad,
    input  logic              wb_rd_en,
    input  logic [REG_AW-1:0] wb_rd_ad,
    output logic [FWD_W-1:0]  fwd_a_c,
    output logic [FWD_W-1:0]  fwd_b_c
);

    // Same compare applied to rs1 and rs2
    always_comb begin
        fwd_a_c = fwd_select(ex_rs1_read, ex_rs1_ad, mem_rd_en, mem_rd_ad, wb_rd_en, wb_rd_ad);
        fwd_b_c = fwd_select(ex_rs2_read, ex_rs2_ad, mem_rd_en, mem_rd_ad, wb_rd_en, wb_rd_ad);
    end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Pipeline hazard and sequencing controller: PC / pipeline-register enables and
// flushes for load-use, taken-branch and data-memory wait, plus EX forwarding.
// Optional performance counters (stall_cnt, flush_cnt) with HAZ_PERF_CNT_EN.
module pip_hazard_ctrl
    import pip_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_ad,
    input  logic [REG_AW-1:0] id_rs2_ad,
    input  logic              id_rs1_read,
    input  logic              id_rs2_read,
    input  logic [REG_AW-1:0] ex_rs1_ad,
    input  logic [REG_AW-1:0] ex_rs2_ad,
    input  logic              ex_rs1_read,
    input  logic              ex_rs2_read,
    input  logic [REG_AW-1:0] ex_rd_ad,
    input  logic              ex_rdEn,
    input  logic              ex_DMread,
    input  logic [REG_AW-1:0] mem_rd_ad,
    input  logic              mem_rdEn,
    input  logic [REG_AW-1:0] wb_rd_ad,
    input  logic              wb_rdEn,
    input  logic              branch_taken,
    input  logic              dm_req,
    input  logic              dm_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]   stall_cnt,
    output logic [XLEN-1:0]   flush_cnt
`endif
);

    // Counter width must be meaningful even when the counters are compiled out
    if (XLEN == 0) begin : g_xlen_chk
        $error("pip_hazard_ctrl: XLEN must be nonzero");
    end

    pip_state_e       state_q;
    pip_state_e       state_d;
    logic             mem_frozen_c;
    logic             load_use_c;
    logic [FWD_W-1:0] fwd_a_c;
    logic [FWD_W-1:0] fwd_b_c;

    // Hazard conditions from inputs and the registered memory-wait state
    always_comb begin
        mem_frozen_c = ((state_q == ST_MEM_WAIT) && !dm_ack)
                     || ((state_q == ST_RUN) && dm_req && !dm_ack);
        load_use_c   = ex_DMread && ex_rdEn && (ex_rd_ad != '0)
                     && ((id_rs1_read && (id_rs1_ad == ex_rd_ad))
                      || (id_rs2_read && (id_rs2_ad == ex_rd_ad)));
    end

    // Memory-wait FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (dm_req && !dm_ack) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (dm_ack)            state_d = ST_RUN;
            default:                            state_d = ST_RUN;
        endcase
    end

    // Memory-wait FSM state register; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Enables and flushes: reset, then memory freeze, branch, load-use in priority order
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_frozen_c) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_c) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    pip_fwd_unit u_fwd (
        .ex_rs1_read (ex_rs1_read),
        .ex_rs1_ad   (ex_rs1_ad),
        .ex_rs2_read (ex_rs2_read),
        .ex_rs2_ad   (ex_rs2_ad),
        .mem_rd_en   (mem_rdEn),
        .mem_rd_ad   (mem_rd_ad),
        .wb_rd_en    (wb_rdEn),
        .wb_rd_ad    (wb_rd_ad),
        .fwd_a_c     (fwd_a_c),
        .fwd_b_c     (fwd_b_c)
    );

    // Forwarding selects forced to the register file while in reset
    always_comb begin
        fwd_a = fwd_a_c;
        fwd_b = fwd_b_c;
        if (rst) begin
            fwd_a = FWD_REG;
            fwd_b = FWD_REG;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q;
    logic [XLEN-1:0] stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q;
    logic [XLEN-1:0] flush_cnt_d;

    // Count PC-stall cycles and branch flushes that actually take effect
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
        if (branch_taken && !mem_frozen_c) begin
            flush_cnt_d = flush_cnt_q + XLEN'(1);
        end
    end

    // Counter registers, cleared by reset and wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Scoreboard bench for pip_hazard_ctrl: directed cases plus random traffic
// checked against a cycle-level behavioural model. Counter checks with HAZ_PERF_CNT_EN.
module tb_pip_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1_ad, id_rs2_ad;
    logic       id_rs1_read, id_rs2_read;
    logic [4:0] ex_rs1_ad, ex_rs2_ad;
    logic       ex_rs1_read, ex_rs2_read;
    logic [4:0] ex_rd_ad;
    logic       ex_rdEn, ex_DMread;
    logic [4:0] mem_rd_ad;
    logic       mem_rdEn;
    logic [4:0] wb_rd_ad;
    logic       wb_rdEn;
    logic       branch_taken, dm_req, dm_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pip_hazard_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_ad    (id_rs1_ad),
        .id_rs2_ad    (id_rs2_ad),
        .id_rs1_read  (id_rs1_read),
        .id_rs2_read  (id_rs2_read),
        .ex_rs1_ad    (ex_rs1_ad),
        .ex_rs2_ad    (ex_rs2_ad),
        .ex_rs1_read  (ex_rs1_read),
        .ex_rs2_read  (ex_rs2_read),
        .ex_rd_ad     (ex_rd_ad),
        .ex_rdEn      (ex_rdEn),
        .ex_DMread    (ex_DMread),
        .mem_rd_ad    (mem_rd_ad),
        .mem_rdEn     (mem_rdEn),
        .wb_rd_ad     (wb_rd_ad),
        .wb_rdEn      (wb_rdEn),
        .branch_taken (branch_taken),
        .dm_req       (dm_req),
        .dm_ack       (dm_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic [4:0] id_rs1_ad, id_rs2_ad;
        logic       id_rs1_read, id_rs2_read;
        logic [4:0] ex_rs1_ad, ex_rs2_ad;
        logic       ex_rs1_read, ex_rs2_read;
        logic [4:0] ex_rd_ad;
        logic       ex_rdEn, ex_DMread;
        logic [4:0] mem_rd_ad;
        logic       mem_rdEn;
        logic [4:0] wb_rd_ad;
        logic       wb_rdEn;
        logic       branch_taken, dm_req, dm_ack;
    } stim_t;

    // ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
    typedef struct {
        logic [6:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        cnt_known;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: an access is outstanding; counter values as seen this cycle
    logic        m_busy = 1'b0, m_busy_n = 1'b0;
    logic        m_known = 1'b0, m_known_n = 1'b0;
    logic [31:0] m_sc = '0, m_sc_n = '0, m_fc = '0, m_fc_n = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_fwd(input logic rd, input logic [4:0] ad,
                                             input stim_t s);
        if (!rd || ad == 5'd0) return 2'b00;
        if (s.mem_rdEn && s.mem_rd_ad == ad) return 2'b01;
        if (s.wb_rdEn && s.wb_rd_ad == ad) return 2'b10;
        return 2'b00;
    endfunction

    task automatic issue(input stim_t s);
        exp_t e;
        logic frozen, lu;
        @(posedge clk);
        m_busy  = m_busy_n;
        m_known = m_known_n;
        m_sc    = m_sc_n;
        m_fc    = m_fc_n;
        #1;
        rst = s.rst;
        id_rs1_ad = s.id_rs1_ad;   id_rs2_ad = s.id_rs2_ad;
        id_rs1_read = s.id_rs1_read; id_rs2_read = s.id_rs2_read;
        ex_rs1_ad = s.ex_rs1_ad;   ex_rs2_ad = s.ex_rs2_ad;
        ex_rs1_read = s.ex_rs1_read; ex_rs2_read = s.ex_rs2_read;
        ex_rd_ad = s.ex_rd_ad; ex_rdEn = s.ex_rdEn; ex_DMread = s.ex_DMread;
        mem_rd_ad = s.mem_rd_ad; mem_rdEn = s.mem_rdEn;
        wb_rd_ad = s.wb_rd_ad; wb_rdEn = s.wb_rdEn;
        branch_taken = s.branch_taken; dm_req = s.dm_req; dm_ack = s.dm_ack;

        // Pipeline is frozen while any access (new or outstanding) lacks its ack
        frozen = !s.rst && (m_busy || s.dm_req) && !s.dm_ack;
        lu = s.ex_DMread && s.ex_rdEn && s.ex_rd_ad != 5'd0 &&
             ((s.id_rs1_read && s.id_rs1_ad == s.ex_rd_ad) ||
              (s.id_rs2_read && s.id_rs2_ad == s.ex_rd_ad));
        if (s.rst)               e.ctrl = 7'b00000_11;
        else if (frozen)         e.ctrl = 7'b00000_00;
        else if (s.branch_taken) e.ctrl = 7'b11111_11;
        else if (lu)             e.ctrl = 7'b00111_01;
        else                     e.ctrl = 7'b11111_00;
        e.fa = s.rst ? 2'b00 : model_fwd(s.ex_rs1_read, s.ex_rs1_ad, s);
        e.fb = s.rst ? 2'b00 : model_fwd(s.ex_rs2_read, s.ex_rs2_ad, s);
        e.cnt_known = m_known;
        e.sc = m_sc;
        e.fc = m_fc;
        q.push_back(e);

        if (s.rst) begin
            m_busy_n = 1'b0; m_known_n = 1'b1; m_sc_n = '0; m_fc_n = '0;
        end else begin
            m_busy_n  = frozen;
            m_known_n = m_known;
            m_sc_n    = m_sc + ((e.ctrl[6] == 1'b0) ? 32'd1 : 32'd0);
            m_fc_n    = m_fc + ((s.branch_taken && !frozen) ? 32'd1 : 32'd0);
        end
    endtask

    // Monitor: every stimulated cycle presents one response, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [6:0] act;
            e = q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t got %b exp %b", $time, act, e.ctrl);
            end
            checks++;
            if (fwd_a !== e.fa) begin
                errors++;
                $display("FAIL fwd_a t=%0t got %b exp %b", $time, fwd_a, e.fa);
            end
            checks++;
            if (fwd_b !== e.fb) begin
                errors++;
                $display("FAIL fwd_b t=%0t got %b exp %b", $time, fwd_b, e.fb);
            end
`ifdef HAZ_PERF_CNT_EN
            if (e.cnt_known) begin
                checks++;
                if (stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.sc);
                end
                checks++;
                if (flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t got %0d exp %0d", $time, flush_cnt, e.fc);
                end
            end
`endif
        end
    end

    initial begin
        stim_t s, idle;
        idle = '{default: '0};
        rst = 1'b1;
        {id_rs1_ad, id_rs2_ad, id_rs1_read, id_rs2_read} = '0;
        {ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read} = '0;
        {ex_rd_ad, ex_rdEn, ex_DMread, mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn} = '0;
        {branch_taken, dm_req, dm_ack} = '0;

        // Reset, then first cycle out of reset
        s = idle; s.rst = 1'b1;
        issue(s); issue(s);
        s = idle; issue(s);

        // Load-use on rs2 = x5: one bubble, then the bubble clears the load
        s = idle; s.ex_DMread = 1; s.ex_rdEn = 1; s.ex_rd_ad = 5;
        s.id_rs2_read = 1; s.id_rs2_ad = 5;
        issue(s);
        s.ex_DMread = 0; s.ex_rdEn = 0; issue(s);

        // Load to x0, and load with rs2 not read: no stall
        s = idle; s.ex_DMread = 1; s.ex_rdEn = 1; s.ex_rd_ad = 0;
        s.id_rs2_read = 1; s.id_rs2_ad = 0; issue(s);
        s.ex_rd_ad = 5; s.id_rs2_ad = 5; s.id_rs2_read = 0; issue(s);

        // Branch wins over load-use
        s.id_rs2_read = 1; s.branch_taken = 1; issue(s);

        // Three memory-wait cycles, branch held from the second, then ack
        s = idle; s.dm_req = 1; issue(s);
        s.branch_taken = 1; issue(s); issue(s);
        s.dm_ack = 1; issue(s);
        s = idle; issue(s);

        // Same-cycle ack: no stall; ack without request: ignored
        s = idle; s.dm_req = 1; s.dm_ack = 1; issue(s);
        s = idle; s.dm_ack = 1; issue(s);

        // Forwarding priority and x0
        s = idle; s.mem_rd_ad = 7; s.wb_rd_ad = 7; s.mem_rdEn = 1; s.wb_rdEn = 1;
        s.ex_rs1_ad = 7; s.ex_rs1_read = 1; s.ex_rs2_ad = 7; s.ex_rs2_read = 1;
        issue(s);
        s.mem_rdEn = 0; issue(s);
        s.mem_rd_ad = 0; s.wb_rd_ad = 0; s.ex_rs1_ad = 0; s.ex_rs2_ad = 0;
        s.mem_rdEn = 1; issue(s);

        // Reset in the middle of a memory wait
        s = idle; s.dm_req = 1; issue(s); issue(s);
        s.rst = 1; issue(s);
        s = idle; issue(s); issue(s);

        // Random traffic over a small register window to provoke hits
        for (int n = 0; n < 3000; n++) begin
            s.rst          = ($urandom_range(0, 79) == 0);
            s.id_rs1_ad    = 5'($urandom_range(0, 3));
            s.id_rs2_ad    = 5'($urandom_range(0, 3));
            s.id_rs1_read  = 1'($urandom_range(0, 1));
            s.id_rs2_read  = 1'($urandom_range(0, 1));
            s.ex_rs1_ad    = 5'($urandom_range(0, 3));
            s.ex_rs2_ad    = 5'($urandom_range(0, 3));
            s.ex_rs1_read  = 1'($urandom_range(0, 1));
            s.ex_rs2_read  = 1'($urandom_range(0, 1));
            s.ex_rd_ad     = 5'($urandom_range(0, 3));
            s.ex_rdEn      = 1'($urandom_range(0, 1));
            s.ex_DMread    = 1'($urandom_range(0, 1));
            s.mem_rd_ad    = 5'($urandom_range(0, 3));
            s.mem_rdEn     = 1'($urandom_range(0, 1));
            s.wb_rd_ad     = 5'($urandom_range(0, 3));
            s.wb_rdEn      = 1'($urandom_range(0, 1));
            s.branch_taken = ($urandom_range(0, 4) == 0);
            s.dm_req       = ($urandom_range(0, 3) == 0);
            s.dm_ack       = ($urandom_range(0, 2) == 0);
            issue(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pip_hazard_ctrl.md
# pip_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It drives the enable and flush inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves load-use stalls, taken-branch flushes and data-memory wait states. It also generates the EX-stage operand forwarding selects from the register addresses and read/write flags carried through the pipeline registers.

## Interface
Parameters:
- `XLEN`, 32: width of the optional performance counters.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `id_rs1_ad`, `id_rs2_ad`  in  5  source addresses of the instruction in decode.
- `id_rs1_read`, `id_rs2_read`  in  1  the decode instruction actually reads rs1 / rs2.
- `ex_rs1_ad`, `ex_rs2_ad`  in  5  source addresses at the ID/EX outputs.
- `ex_rs1_read`, `ex_rs2_read`  in  1  read flags at the ID/EX outputs.
- `ex_rd_ad`  in  5  destination address at the ID/EX outputs.
- `ex_rdEn`, `ex_DMread`  in  1  writeback and load flags at the ID/EX outputs.
- `mem_rd_ad`  in  5  destination address at the EX/MEM outputs.
- `mem_rdEn`  in  1  writeback flag at the EX/MEM outputs.
- `wb_rd_ad`  in  5  destination address at the MEM/WB outputs.
- `wb_rdEn`  in  1  writeback flag at the MEM/WB outputs.
- `branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `dm_req`  in  1  MEM stage issues a data-memory access this cycle.
- `dm_ack`  in  1  data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  `pip_en` for the PC and each pipeline register.
- `if_id_flush`, `id_ex_flush`  out  1  load a bubble: all control fields zeroed, so `rdEn`, `DMwriteEn` and `DMread` are 0.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 = register value, 01 = EX/MEM result, 10 = MEM/WB result. 11 is never driven.
- `stall_cnt`, `flush_cnt`  out  `XLEN`  performance counters; present only with `HAZ_PERF_CNT_EN`.

## Operation
FSM states:
- RUN, the reset state.
- MEM_WAIT.

RUN → MEM_WAIT when `dm_req & ~dm_ack`. MEM_WAIT → RUN when `dm_ack`. MEM_WAIT holds while `~dm_ack`.

The combinational hazard condition is evaluated in priority order; the first that applies wins:
1. Memory wait: `(state==MEM_WAIT & ~dm_ack) | (state==RUN & dm_req & ~dm_ack)`. All five enables are 0 and both flushes are 0, so the whole pipeline freezes.
2. Branch: `branch_taken`. All enables are 1, `if_id_flush=1` and `id_ex_flush=1`, giving a 2-bubble penalty. A branch that coincides with a load-use condition is a branch: the stall is discarded.
3. Load-use: `ex_DMread & ex_rdEn & ex_rd_ad!=0`, and (`id_rs1_read & id_rs1_ad==ex_rd_ad`) or (`id_rs2_read & id_rs2_ad==ex_rd_ad`). Then:
   - `pc_en=0` and `if_id_en=0`;
   - `id_ex_en=1` with `id_ex_flush=1`;
   - `ex_mem_en=1` and `mem_wb_en=1`.
   This is exactly one bubble, because the bubble clears `ex_DMread` on the next cycle.
4. Otherwise: all enables 1, both flushes 0.

Forwarding, with `fwd_b` identical to `fwd_a` using the rs2 signals:
- `fwd_a=01` if `ex_rs1_read & mem_rdEn & mem_rd_ad!=0 & mem_rd_ad==ex_rs1_ad`;
- else `fwd_a=10` if the same condition holds with the `wb_*` signals;
- else `fwd_a=00`.

MEM has priority over WB. x0 is never forwarded. Forwarding is not gated by the stall state, since frozen stages hold their inputs.

## Timing
- Reset (`rst=1` at an edge):
  - `state=RUN`, counters cleared;
  - while `rst` is high, all enables are 0, both flushes are 1 and `fwd_a=fwd_b=00`.
  - The first cycle after reset deasserts has all enables 1.
- Hazard outputs are combinational from the inputs and the registered state. They take effect at the same edge (zero-cycle latency).
- `dm_ack` in the same cycle as `dm_req` gives no stall and no state change.
- A `branch_taken` that arrives during MEM_WAIT is held by the frozen ID/EX and EX stage. It is acted on in the cycle `dm_ack` arrives: the branch flush and the enables assert together.
- `dm_ack` without `dm_req` in RUN is ignored.
- `rst` asserted during MEM_WAIT returns to RUN at that edge. The outstanding access is abandoned.

## Configuration
- `HAZ_PERF_CNT_EN` defined: `stall_cnt` and `flush_cnt` ports and registers exist.
  - `stall_cnt` increments on every cycle with `pc_en==0` outside reset.
  - `flush_cnt` increments on every cycle with `branch_taken` that is not memory-frozen.
  - Both wrap modulo 2^XLEN.
- `HAZ_PERF_CNT_EN` undefined: the ports are absent and there is no counter logic.

## Structure
- Shared package `pip_pkg`:
  - forwarding select constants `FWD_REG=2'b00`, `FWD_MEM=2'b01`, `FWD_WB=2'b10`;
  - FSM state encoding `ST_RUN`, `ST_MEM_WAIT`.
- One sub-module, `pip_fwd_unit`: the pure combinational forwarding compare, instantiated once.

## Test plan
- `lw x5` in EX (`ex_DMread=1`, `ex_rd_ad=5`), decode reads rs2=x5 → one cycle with `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`; next cycle all enables 1.
- The same load with `ex_rd_ad=0`, or with `id_rs2_read=0` → no stall.
- `branch_taken=1` while the load-use condition holds → `if_id_flush=1`, `id_ex_flush=1`, `pc_en=1`, no stall.
- `dm_req=1`, `dm_ack=0` for 3 cycles, with `branch_taken=1` held from cycle 2 → all enables 0 for 3 cycles; ack cycle gives enables 1 plus both flushes; `stall_cnt=3`.
- `mem_rd_ad=wb_rd_ad=7`, both `rdEn`, `ex_rs1_ad=7` → `fwd_a=01`; with `mem_rdEn=0` → `fwd_a=10`; with address 0 → `00`.
- `rst` pulsed mid-MEM_WAIT → next cycle state RUN, enables 1, counters 0.
